// File: rtl/iobuff_cfg_sequencer.sv
// iobuff_cfg_sequencer
//   Owns the oe/od/dir/din controls of NUM_PINS iobuff channels and applies
//   mode changes glitch-free: the target pin is parked Hi-Z for DEAD_CYCLES,
//   then the new od/dir/level is presented with OE still low for
//   SETTLE_CYCLES, and only then is OE raised. A command that keeps the
//   stored mode only updates the drive level, with no Hi-Z gap.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   cmd_valid/ready  command handshake (accepted when both high at clk edge)
//   cmd_pin          target pin index
//   cmd_mode         0=Hi-Z input, 1=push-pull, 2=open-drain, 3=reserved
//   cmd_level        output level to drive
//   all_hiz          emergency: force every pin Hi-Z, abort any sequence
//   busy             sequence in progress
//   done, err        one-cycle completion pulse / rejection flag
//   pin_oe/od/dir/din  per-pin iobuff controls (dir: 1=input)
module iobuff_cfg_sequencer #(
  parameter int NUM_PINS      = 8,
  parameter int PIN_W         = 3,
  parameter int DEAD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PIN_W-1:0]    cmd_pin,
  input  logic [1:0]          cmd_mode,
  input  logic                cmd_level,
  input  logic                all_hiz,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [NUM_PINS-1:0] pin_oe,
  output logic [NUM_PINS-1:0] pin_od,
  output logic [NUM_PINS-1:0] pin_dir,
  output logic [NUM_PINS-1:0] pin_din
);

  localparam int MAX_CYC = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HIZ   = 2'd1;
  localparam logic [1:0] ST_SETUP = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]             state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [PIN_W-1:0]       pin_reg;
  logic [1:0]             mode_lat_reg;
  logic                   level_lat_reg;
  logic                   ready_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   err_reg;
  logic [NUM_PINS-1:0][1:0] mode_reg;
  logic [NUM_PINS-1:0]    oe_reg;
  logic [NUM_PINS-1:0]    od_reg;
  logic [NUM_PINS-1:0]    dir_reg;
  logic [NUM_PINS-1:0]    din_reg;

  logic                   accept;
  logic                   cmd_reject;
  logic                   cmd_same;
  logic [1:0]             cur_mode;
  logic [NUM_PINS-1:0]    cmd_sel;
  logic [NUM_PINS-1:0]    lat_sel;
  logic                   setup_apply;
  logic                   enable_apply;

  assign accept = (state_reg == ST_IDLE) && cmd_valid && ready_reg;

  // Decode both the incoming and the latched pin index by comparison so an
  // out-of-range index simply selects nothing.
  always_comb begin
    cur_mode = 2'd0;
    cmd_sel  = '0;
    lat_sel  = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (cmd_pin == PIN_W'(i)) begin
        cur_mode   = mode_reg[i];
        cmd_sel[i] = 1'b1;
      end
      if (pin_reg == PIN_W'(i)) begin
        lat_sel[i] = 1'b1;
      end
    end
  end

  assign cmd_reject = (32'(cmd_pin) >= 32'(NUM_PINS)) || (cmd_mode == 2'd3);
  assign cmd_same   = (cmd_mode == cur_mode);

  // Strobes fire on the last cycle of HIZ / SETUP so the pin registers
  // change exactly when the FSM enters the following state.
  assign setup_apply  = (state_reg == ST_HIZ)   && (cnt_reg == CNT_W'(1));
  assign enable_apply = (state_reg == ST_SETUP) && (cnt_reg == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      pin_reg       <= '0;
      mode_lat_reg  <= 2'd0;
      level_lat_reg <= 1'b0;
      ready_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else if (all_hiz) begin
      state_reg <= ST_IDLE;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            pin_reg       <= cmd_pin;
            mode_lat_reg  <= cmd_mode;
            level_lat_reg <= cmd_level;
            ready_reg     <= 1'b0;
            busy_reg      <= 1'b1;
            if (cmd_reject || cmd_same) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              err_reg   <= cmd_reject;
            end else begin
              state_reg <= ST_HIZ;
              cnt_reg   <= CNT_W'(DEAD_CYCLES);
            end
          end else begin
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        ST_HIZ: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= ST_SETUP;
            cnt_reg   <= CNT_W'(SETTLE_CYCLES);
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_SETUP: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Per-pin control registers; only the selected pin ever changes.
  generate
    for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
      always_ff @(posedge clk) begin
        if (rst) begin
          oe_reg[gi]   <= 1'b0;
          od_reg[gi]   <= 1'b0;
          dir_reg[gi]  <= 1'b1;
          din_reg[gi]  <= 1'b1;
          mode_reg[gi] <= 2'd0;
        end else if (all_hiz) begin
          oe_reg[gi]   <= 1'b0;
          dir_reg[gi]  <= 1'b1;
          mode_reg[gi] <= 2'd0;
        end else begin
          if (accept && cmd_sel[gi] && !cmd_reject) begin
            if (cmd_same) begin
              din_reg[gi] <= cmd_level;
            end else begin
              oe_reg[gi] <= 1'b0;
            end
          end
          if (setup_apply && lat_sel[gi]) begin
            od_reg[gi]  <= (mode_lat_reg == 2'd2);
            dir_reg[gi] <= (mode_lat_reg == 2'd0);
            din_reg[gi] <= level_lat_reg;
          end
          if (enable_apply && lat_sel[gi]) begin
            oe_reg[gi]   <= (mode_lat_reg != 2'd0);
            mode_reg[gi] <= mode_lat_reg;
          end
        end
      end
    end
  endgenerate

  assign cmd_ready = ready_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign pin_oe    = oe_reg;
  assign pin_od    = od_reg;
  assign pin_dir   = dir_reg;
  assign pin_din   = din_reg;

endmodule
